// File: rtl/traffic_pkg.sv
// Shared types and light encodings for the intersection phase controller
// and the delay timer it drives.
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_GREEN  = 3'd0,
        MAIN_YELLOW = 3'd1,
        SIDE_GREEN  = 3'd2,
        SIDE_YELLOW = 3'd3,
        FLASH_ON    = 3'd4,
        FLASH_OFF   = 3'd5
    } phase_t;

    localparam logic [2:0] LIGHT_RED = 3'b100;
    localparam logic [2:0] LIGHT_YEL = 3'b010;
    localparam logic [2:0] LIGHT_GRN = 3'b001;
    localparam logic [2:0] LIGHT_OFF = 3'b000;

    function automatic logic [2:0] main_light_of(input phase_t p);
        case (p)
            MAIN_GREEN:  return LIGHT_GRN;
            MAIN_YELLOW: return LIGHT_YEL;
            SIDE_GREEN:  return LIGHT_RED;
            SIDE_YELLOW: return LIGHT_RED;
            FLASH_ON:    return LIGHT_YEL;
            default:     return LIGHT_OFF;
        endcase
    endfunction

    function automatic logic [2:0] side_light_of(input phase_t p);
        case (p)
            MAIN_GREEN:  return LIGHT_RED;
            MAIN_YELLOW: return LIGHT_RED;
            SIDE_GREEN:  return LIGHT_GRN;
            SIDE_YELLOW: return LIGHT_YEL;
            FLASH_ON:    return LIGHT_YEL;
            default:     return LIGHT_OFF;
        endcase
    endfunction

    // Green phases use the long delay; yellow and flash phases the short one.
    function automatic logic is_green(input phase_t p);
        return (p == MAIN_GREEN) || (p == SIDE_GREEN);
    endfunction

endpackage

// File: rtl/timer_handshake.sv
// Turns trigger requests into registered one-cycle timer starts and qualifies
// the timer's sticky done flag so a stale flag from the previous delay is ignored.
module timer_handshake (
    input  logic clk,
    input  logic rst,
    input  logic long_req,
    input  logic short_req,
    input  logic timer_done,
    output logic start_long,
    output logic start_short,
    output logic expire
);

    logic start_pend_q, start_pend_d;
    logic start_long_q, start_long_d;
    logic start_short_q, start_short_d;
    logic armed_q, armed_d;

    always_comb begin
        start_pend_d  = 1'b0;
        start_long_d  = start_pend_q | long_req;
        start_short_d = short_req & ~start_long_d;
        // Arm only after done has been seen low since the latest trigger.
        if (start_long_d || start_short_d) begin
            armed_d = 1'b0;
        end else begin
            armed_d = armed_q | ~timer_done;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_pend_q  <= 1'b1;
            start_long_q  <= 1'b0;
            start_short_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            start_pend_q  <= start_pend_d;
            start_long_q  <= start_long_d;
            start_short_q <= start_short_d;
            armed_q       <= armed_d;
        end
    end

    assign start_long  = start_long_q;
    assign start_short = start_short_q;
    assign expire      = armed_q & timer_done;

endmodule

// File: rtl/traffic_phase_controller.sv
// Four-phase intersection controller with pedestrian walk and flashing-yellow mode.
//   state       | meaning
//   MAIN_GREEN  | main G, side R; holds until side car or ped request at expiry
//   MAIN_YELLOW | main Y, side R
//   SIDE_GREEN  | main R, side G; walk lit if entered with a ped request pending
//   SIDE_YELLOW | main R, side Y
//   FLASH_ON    | both heads yellow
//   FLASH_OFF   | both heads dark
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter bit PED_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       side_car,
    input  logic       ped_req,
    input  logic       flash_mode,
    input  logic       Timer_done,
    output logic       Start_LongTimer,
    output logic       Start_ShortTimer,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    phase_t     state_q, state_d;
    logic       ped_pending_q, ped_pending_d;
    logic       walk_q, walk_d;
    logic [2:0] main_light_q, main_light_d;
    logic [2:0] side_light_q, side_light_d;
    logic       expire;
    logic       ped_req_eff;
    logic       change;
    logic       enter_side_green;
    logic       long_req, short_req;

    timer_handshake u_timer_handshake (
        .clk        (clk),
        .rst        (rst),
        .long_req   (long_req),
        .short_req  (short_req),
        .timer_done (Timer_done),
        .start_long (Start_LongTimer),
        .start_short(Start_ShortTimer),
        .expire     (expire)
    );

    always_comb begin
        ped_req_eff = PED_ENABLE & ped_req;
        state_d     = state_q;
        if (expire) begin
            if (flash_mode) begin
                state_d = (state_q == FLASH_ON) ? FLASH_OFF : FLASH_ON;
            end else begin
                case (state_q)
                    MAIN_GREEN: begin
                        if (side_car || ped_pending_q || ped_req_eff) begin
                            state_d = MAIN_YELLOW;
                        end
                    end
                    MAIN_YELLOW: state_d = SIDE_GREEN;
                    SIDE_GREEN:  state_d = SIDE_YELLOW;
                    SIDE_YELLOW: state_d = MAIN_GREEN;
                    default:     state_d = MAIN_GREEN;
                endcase
            end
        end

        // Every real transition changes state, so a change is a state entry.
        change           = (state_d != state_q);
        long_req         = change & is_green(state_d);
        short_req        = change & ~is_green(state_d);
        enter_side_green = change & (state_d == SIDE_GREEN);

        ped_pending_d = enter_side_green ? 1'b0 : (ped_pending_q | ped_req_eff);
        if (enter_side_green) begin
            walk_d = ped_pending_q | ped_req_eff;
        end else if (state_d == SIDE_GREEN) begin
            walk_d = walk_q;
        end else begin
            walk_d = 1'b0;
        end

        main_light_d = main_light_of(state_d);
        side_light_d = side_light_of(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= MAIN_GREEN;
            ped_pending_q <= 1'b0;
            walk_q        <= 1'b0;
            main_light_q  <= LIGHT_GRN;
            side_light_q  <= LIGHT_RED;
        end else begin
            state_q       <= state_d;
            ped_pending_q <= ped_pending_d;
            walk_q        <= walk_d;
            main_light_q  <= main_light_d;
            side_light_q  <= side_light_d;
        end
    end

    assign main_light = main_light_q;
    assign side_light = side_light_q;
    assign walk       = PED_ENABLE & walk_q;
    assign phase      = state_q;

endmodule
